// File: rtl/pe_image_packetizer.sv
// rtl/pe_image_packetizer.sv - streams a rows x cols pixel RAM image out as one head/body/tail NoC packet
module pe_image_packetizer #(
    parameter int rows              = 273,
    parameter int cols              = 182,
    parameter int X                 = 3,
    parameter int Y                 = 3,
    parameter int id_width          = 2,
    parameter int data_width        = 24,
    parameter int pkt_no_field_size = 4,
    parameter int x_size            = $clog2(X),
    parameter int y_size            = $clog2(Y),
    parameter int total_width       = x_size + y_size + pkt_no_field_size + id_width + data_width,
    parameter int addr_width        = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [x_size-1:0]            dest_x,
    input  logic [y_size-1:0]            dest_y,
    output logic                         pix_rd_en,
    output logic [addr_width-1:0]        pix_addr,
    input  logic [data_width-1:0]        pix_data,
    output logic                         w_valid_pe,
    input  logic                         w_ready_pe,
    output logic [total_width-1:0]       w_data_pe,
    output logic                         busy,
    output logic                         done,
    output logic [pkt_no_field_size-1:0] pkt_no
);

    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

    localparam int npix  = rows * cols;
    localparam int cnt_w = $clog2(npix + 1);
    localparam logic [cnt_w-1:0]      all_reads = cnt_w'(npix);
    localparam logic [cnt_w-1:0]      last_body = cnt_w'(npix - 1);
    localparam logic [data_width-1:0] head_data = data_width'({12'(rows), 12'(cols)});
    localparam logic [id_width-1:0]   type_head = id_width'(0);
    localparam logic [id_width-1:0]   type_body = id_width'(1);
    localparam logic [id_width-1:0]   type_tail = id_width'(3);

    state_t                         state, state_nxt;
    logic [x_size-1:0]              dx_q;
    logic [y_size-1:0]              dy_q;
    logic [pkt_no_field_size-1:0]   pkt_q;
    logic [cnt_w-1:0]               rd_cnt;
    logic [cnt_w-1:0]               body_cnt;
    logic [data_width-1:0]          csum;
    logic [data_width-1:0]          buf0;
    logic [data_width-1:0]          buf1;
    logic [1:0]                     buf_cnt;
    logic                           rd_pend;
    logic                           done_q;

    logic                           start_acc;
    logic                           hs;
    logic                           pop;
    logic                           rd_en;
    logic [2:0]                     occ;
    logic                           valid;
    logic [id_width-1:0]            ftype;
    logic [data_width-1:0]          fdata;

    // the done cycle is already IDLE, so it is excluded explicitly
    assign start_acc = (state == IDLE) && start && !done_q;
    assign hs        = valid && w_ready_pe;
    assign pop       = (state == BODY) && hs;

    // occupancy counts the entry leaving this cycle so the buffer streams without bubbles
    assign occ   = 3'(buf_cnt) - 3'(pop) + 3'(rd_pend);
    assign rd_en = ((state != IDLE) || start_acc) && (rd_cnt != all_reads) && (occ < 3'd2);

    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        ftype     = '0;
        fdata     = '0;
        case (state)
            IDLE: begin
                if (start_acc) state_nxt = HEAD;
            end
            HEAD: begin
                valid = 1'b1;
                ftype = type_head;
                fdata = head_data;
                if (w_ready_pe) state_nxt = BODY;
            end
            BODY: begin
                valid = (buf_cnt != 2'd0);
                ftype = type_body;
                fdata = buf0;
                if (hs && (body_cnt == last_body)) state_nxt = TAIL;
            end
            TAIL: begin
                valid = 1'b1;
                ftype = type_tail;
                fdata = csum;
                if (w_ready_pe) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            dx_q     <= '0;
            dy_q     <= '0;
            pkt_q    <= '0;
            rd_cnt   <= '0;
            body_cnt <= '0;
            csum     <= '0;
            buf0     <= '0;
            buf1     <= '0;
            buf_cnt  <= '0;
            rd_pend  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= rd_en;
            done_q  <= 1'b0;
            if (start_acc) begin
                dx_q <= dest_x;
                dy_q <= dest_y;
                csum <= '0;
            end
            case ({rd_pend, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) buf0 <= pix_data;
                    else                 buf1 <= pix_data;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= pix_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= pix_data;
                    end
                end
                default: ;
            endcase
            if (pop) begin
                csum     <= csum + buf0;
                body_cnt <= body_cnt + 1'b1;
            end
            if ((state == TAIL) && w_ready_pe) begin
                pkt_q    <= pkt_q + 1'b1;
                rd_cnt   <= '0;
                body_cnt <= '0;
                done_q   <= 1'b1;
            end else if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    assign pix_rd_en  = rd_en;
    assign pix_addr   = addr_width'(rd_cnt);
    assign w_valid_pe = valid;
    assign w_data_pe  = valid ? {dx_q, dy_q, pkt_q, ftype, fdata} : '0;
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign pkt_no     = pkt_q;

endmodule

// File: tb/tb_pe_image_packetizer.sv
// tb/tb_pe_image_packetizer.sv - directed/randomized checks of pe_image_packetizer against a packet-level model
`define CHK(tag, obs, exp) begin n_chk++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

module tb_pe_image_packetizer;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int NPIX = ROWS * COLS;
    localparam int TW   = 34;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    dest_x = '0;
    logic [1:0]    dest_y = '0;
    logic          pix_rd_en;
    logic [15:0]   pix_addr;
    logic [23:0]   pix_data = '0;
    logic          w_valid_pe;
    logic          w_ready_pe = 1'b1;
    logic [TW-1:0] w_data_pe;
    logic          busy;
    logic          done;
    logic [3:0]    pkt_no;

    pe_image_packetizer #(.rows(ROWS), .cols(COLS)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .dest_x     (dest_x),
        .dest_y     (dest_y),
        .pix_rd_en  (pix_rd_en),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .w_valid_pe (w_valid_pe),
        .w_ready_pe (w_ready_pe),
        .w_data_pe  (w_data_pe),
        .busy       (busy),
        .done       (done),
        .pkt_no     (pkt_no)
    );

    always #5 clk = ~clk;

    logic [23:0] ram [8];
    always @(posedge clk) if (pix_rd_en) pix_data <= ram[pix_addr[2:0]];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_pkt = 0;
    int   rmode = 0;
    logic rfix = 1'b1;

    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       w_ready_pe = rfix;
            1:       w_ready_pe = ~w_ready_pe;
            default: w_ready_pe = 1'($urandom_range(0, 1));
        endcase
    end

    logic [TW-1:0] got_q[$];
    int            hs_cyc[$];
    int            read_q[$];
    int            done_n = 0;
    int            done_cyc = -1;
    int            stab_err = 0;
    logic          prev_v = 1'b0;
    logic          prev_hs = 1'b0;
    logic [TW-1:0] prev_d = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_v && !prev_hs && (!w_valid_pe || (w_data_pe !== prev_d))) stab_err++;
            if (w_valid_pe && w_ready_pe) begin
                got_q.push_back(w_data_pe);
                hs_cyc.push_back(cyc);
            end
            if (pix_rd_en) read_q.push_back(int'(pix_addr));
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            prev_v  = w_valid_pe;
            prev_hs = w_valid_pe && w_ready_pe;
            prev_d  = w_data_pe;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
        exp_pkt = 0;
    endtask

    task automatic fill_ram(input int mode);
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0:       ram[i] = 24'(i + 1);
                1:       ram[i] = 24'hFFFFFF;
                default: ram[i] = 24'($urandom);
            endcase
        end
    endtask

    task automatic start_pkt(input logic [1:0] dx, input logic [1:0] dy, output int s);
        got_q.delete();
        hs_cyc.delete();
        read_q.delete();
        done_n   = 0;
        done_cyc = -1;
        `CHK("idle_before_start", busy, 1'b0)
        dest_x = dx;
        dest_y = dy;
        start  = 1'b1;
        s      = cyc;
        tick(1);
        start  = 1'b0;
        dest_x = ~dx;
        dest_y = ~dy;
    endtask

    // extra: also pulse start while busy and during the done cycle
    task automatic wait_done(input bit extra);
        bit seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = extra && (k == 2);
            tick(1);
        end
        start = extra;
        tick(1);
        start = 1'b0;
        `CHK("done_timeout", seen, 1'b1)
    endtask

    task automatic check_pkt(input logic [1:0] dx, input logic [1:0] dy, input int s, input bit timed);
        logic [TW-1:0] exp_q[$];
        int            sum = 0;
        exp_q.push_back({dx, dy, 4'(exp_pkt), 2'b00, 12'(ROWS), 12'(COLS)});
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back({dx, dy, 4'(exp_pkt), 2'b01, ram[i]});
            sum += int'(ram[i]);
        end
        exp_q.push_back({dx, dy, 4'(exp_pkt), 2'b11, 24'(sum)});
        `CHK("flit_count", got_q.size(), NPIX + 2)
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) `CHK($sformatf("flit%0d", i), got_q[i], exp_q[i])
        end
        `CHK("done_pulses", done_n, 1)
        if (hs_cyc.size() > 0) begin
            `CHK("done_after_tail", done_cyc, hs_cyc[$] + 1)
            if (timed) begin
                `CHK("head_latency", hs_cyc[0], s + 1)
                `CHK("tail_cycle", hs_cyc[$], s + NPIX + 2)
            end
        end
        `CHK("flit_stable", stab_err, 0)
        exp_pkt = (exp_pkt + 1) % 16;
    endtask

    initial begin
        int s;
        logic [1:0] dx, dy;

        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [1:0] dx, dy;
        bit reached;

        tick(2);
        `CHK("rst_valid", w_valid_pe, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_rd_en", pix_rd_en, 1'b0)
        `CHK("rst_pkt_no", pkt_no, 4'd0)
        `CHK("rst_addr", pix_addr, 16'd0)
        `CHK("rst_data", w_data_pe, 34'd0)
        rstn = 1'b1;
        tick(1);

        // full-rate packet
        fill_ram(0);
        rmode = 0;
        rfix  = 1'b1;
        start_pkt(2'd2, 2'd1, s);
        wait_done(1'b0);
        check_pkt(2'd2, 2'd1, s, 1'b1);
        if (got_q.size() == NPIX + 2) `CHK("tail_sum_1to6", got_q[$][23:0], 24'h000015)

        // alternating ready
        rmode = 1;
        start_pkt(2'd2, 2'd1, s);
        wait_done(1'b0);
        check_pkt(2'd2, 2'd1, s, 1'b0);
        `CHK("read_count", read_q.size(), NPIX)
        for (int i = 0; i < read_q.size(); i++) `CHK($sformatf("read_addr%0d", i), read_q[i], i)

        // 17 back-to-back packets from reset, random data/ready, stray starts
        do_reset();
        rmode = 2;
        for (int p = 0; p < 17; p++) begin
            fill_ram(2);
            dx = 2'($urandom_range(0, 2));
            dy = 2'($urandom_range(0, 2));
            start_pkt(dx, dy, s);
            wait_done(1'b1);
            check_pkt(dx, dy, s, 1'b0);
        end
        `CHK("pkt_no_wrap", pkt_no, 4'(exp_pkt))
        `CHK("no_stray_packet", busy, 1'b0)

        // checksum wrap
        fill_ram(1);
        rmode = 0;
        rfix  = 1'b1;
        start_pkt(2'd1, 2'd2, s);
        wait_done(1'b0);
        check_pkt(2'd1, 2'd2, s, 1'b1);
        if (got_q.size() == NPIX + 2) `CHK("tail_sum_wrap", got_q[$][23:0], 24'hFFFFFA)

        // long stall after head becomes valid
        fill_ram(2);
        rfix = 1'b0;
        start_pkt(2'd0, 2'd2, s);
        tick(11);
        `CHK("stall_reads_le2", (read_q.size() <= 2), 1'b1)
        `CHK("stall_valid", w_valid_pe, 1'b1)
        `CHK("stall_no_hs", got_q.size(), 0)
        rfix = 1'b1;
        wait_done(1'b0);
        check_pkt(2'd0, 2'd2, s, 1'b0);

        // reset while the third body flit is on the wire
        fill_ram(2);
        start_pkt(2'd2, 2'd2, s);
        reached = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (got_q.size() == 3) begin
                reached = 1'b1;
                break;
            end
            tick(1);
        end
        `CHK("reach_body2", reached, 1'b1)
        rstn = 1'b0;
        #1;
        `CHK("midrst_valid", w_valid_pe, 1'b0)
        `CHK("midrst_busy", busy, 1'b0)
        `CHK("midrst_pkt_no", pkt_no, 4'd0)
        tick(2);
        rstn = 1'b1;
        tick(1);
        exp_pkt = 0;
        fill_ram(2);
        start_pkt(2'd1, 2'd0, s);
        wait_done(1'b0);
        check_pkt(2'd1, 2'd0, s, 1'b1);
        if (read_q.size() > 0) `CHK("midrst_first_addr", read_q[0], 0)

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_image_packetizer.md
Name: pe_image_packetizer

Overview:
- Transmit-side counterpart of the region-growing PE's receive path. On a start pulse it reads a rows×cols RGB image from an external single-port pixel RAM and emits one NoC packet on a valid/ready flit interface.
- Each packet is one head flit, rows*cols body flits and one tail flit.
- It sits between the image source memory and the router local port that feeds a PE. It also serves as the bench-side stimulus engine for PEs.

Parameters:
- rows, 273, image height in pixels
- cols, 182, image width in pixels
- X, 3, mesh columns
- Y, 3, mesh rows
- id_width, 2, flit-type field width
- data_width, 24, payload width (R[23:16] G[15:8] B[7:0])
- pkt_no_field_size, 4, packet-number field width
- x_size, $clog2(X), destination-x field width
- y_size, $clog2(Y), destination-y field width
- total_width, x_size+y_size+pkt_no_field_size+id_width+data_width, flit width (34)
- addr_width, 16, pixel RAM address width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to send one image packet
- dest_x  in  x_size  destination router x, sampled with start
- dest_y  in  y_size  destination router y, sampled with start
- pix_rd_en  out  1  pixel RAM read enable
- pix_addr  out  addr_width  pixel RAM address, row-major (r*cols+c)
- pix_data  in  data_width  RAM read data, valid exactly 1 cycle after pix_rd_en
- w_valid_pe  out  1  flit valid
- w_ready_pe  in  1  flit accepted when valid&ready
- w_data_pe  out  total_width  flit
- busy  out  1  packet in progress
- done  out  1  one-cycle pulse after tail accepted
- pkt_no  out  pkt_no_field_size  number of the current/next packet

Behaviour:
- Flit layout, MSB to LSB: dest_x, dest_y, pkt_no, type[25:24], data[23:0].
- Type codes: head=2'b00, body=2'b01, tail=2'b11; 2'b10 is never emitted.
- Head data = {rows[11:0], cols[11:0]}.
- Body data = pixel RAM word, row-major order starting at address 0.
- Tail data = sum of all body data, modulo 2^24.
- Reset (async, immediate) clears: w_valid_pe, busy, done, pix_rd_en, pkt_no, pix_addr, checksum and prefetch buffer to 0. State goes to IDLE. w_data_pe resets to 0.
- FSM states: IDLE, HEAD, BODY, TAIL.
  - IDLE: start accepted only here. dest_x/dest_y are latched; state goes to HEAD; busy goes high the next cycle.
  - start while busy or during the done cycle is ignored and has no side effects.
  - HEAD: drive the head flit; go to BODY on handshake.
  - BODY: drive buffered pixels; go to TAIL on handshake of body flit number rows*cols-1.
  - TAIL: drive the tail flit. On handshake: go to IDLE, busy drops, done pulses for 1 cycle, pkt_no increments (wrapping 2^pkt_no_field_size-1 to 0).
- Handshake rules:
  - Once w_valid_pe is high, w_data_pe is held stable until w_ready_pe is sampled high.
  - w_valid_pe never depends combinationally on w_ready_pe.
- Prefetch:
  - A 2-entry pixel buffer absorbs the 1-cycle RAM latency.
  - pix_rd_en may assert in the same cycle start is accepted.
  - A read is issued only if buffered entries plus reads in flight < 2.
  - Exactly rows*cols reads are issued per packet, never more.
- Throughput: with w_ready_pe held high, the packet occupies rows*cols+2 consecutive cycles. The head flit is valid the cycle after start, with no bubbles.
- Backpressure: w_ready_pe low for any duration stalls output and stops reads once the buffer is full. No pixel is lost or duplicated.
- Checksum accumulates on each body handshake, not on each read.
- Reset mid-packet: the packet is abandoned, no tail is sent, and the next start begins at address 0 with pkt_no=0.

Test Plan:
- rows=2, cols=3, RAM = 0x000001..0x000006, dest (2,1), w_ready_pe=1, start → 8 consecutive flits.
  - Types: 00, 01×6, 11.
  - Head data 0x002003; bodies 1..6 in order; tail data 0x000015.
  - Fields x=2, y=1, pkt_no=0; done 1 cycle after tail.
- Same image, w_ready_pe toggling 1/0 every cycle → identical flit sequence, each flit stable while stalled, pix_rd_en reads exactly 6 addresses 0..5.
- Run 17 back-to-back packets → pkt_no field goes 0..15 then 0; start pulses asserted while busy are ignored, giving no extra packet.
- RAM words 0xFFFFFF×6 → tail data 0xFFFFFA (mod 2^24 wrap).
- Assert rstn low during the 3rd body flit → w_valid_pe low immediately (async). After release, a new start yields a head with pkt_no=0 and a first body from address 0.
- w_ready_pe low for 10 cycles after the head is valid → at most 2 reads issued in total; no lost pixels on release.
